// File: rtl/shufflev_issue_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflev_pkg: shared types, LFSR constants and circular first-set search   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package shufflev_pkg;

  localparam int               LFSR_W            = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS        = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam int               DEPTH_DEFAULT     = 5;
  localparam int               MAX_DEPTH         = 16;

  typedef struct packed {
    logic valid;
    logic barrier;
  } slot_state_t;

  // Lowest circular distance from start wins; returns 0 when mask is empty.
  function automatic int first_set_circ(input logic [MAX_DEPTH-1:0] mask,
                                        input int                   start,
                                        input int                   depth);
    int res;
    int idx;
    res = 0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (i < depth) begin
        idx = start + i;
        if (idx >= depth) idx = idx - depth;
        if (mask[4'(idx)]) res = idx;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shufflev_issue_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflev_issue_scheduler_if: fetch push / issue pop handshake bundle       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface shufflev_issue_scheduler_if
  import shufflev_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             push_i;
  logic             push_barrier_i;
  logic             push_ready_o;
  logic [IDX_W-1:0] push_idx_o;
  logic             pop_valid_o;
  logic [IDX_W-1:0] pop_idx_o;
  logic             pop_ready_i;

  modport master (
    output push_i, push_barrier_i, pop_ready_i,
    input  push_ready_o, push_idx_o, pop_valid_o, pop_idx_o
  );

  modport slave (
    input  push_i, push_barrier_i, pop_ready_i,
    output push_ready_o, push_idx_o, pop_valid_o, pop_idx_o
  );

endinterface
`default_nettype wire

// File: rtl/shufflev_issue_scheduler_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflev_lfsr: 16-bit right-shifting Galois LFSR with load and zero guard  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module shufflev_lfsr
  import shufflev_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              load_i,
  input  wire logic [LFSR_W-1:0] seed_i,
  input  wire logic              advance_i,
  output logic      [7:0]        rand_o
);

  localparam logic [LFSR_W-1:0] c_ZERO_SEED_SUB = 16'h0001;

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_step;

  assign w_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign rand_o = r_lfsr[7:0];

  // An all-zero state would lock up, so a zero seed is replaced.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= SEED;
    end else if (load_i) begin
      r_lfsr <= (seed_i == '0) ? c_ZERO_SEED_SUB : seed_i;
    end else if (advance_i) begin
      r_lfsr <= w_step;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shufflev_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shufflev_issue_scheduler: slot allocation and barrier-fenced random issue  |
// | Optional: SHUFFLEV_SCHED_PERF_EN adds saturating out-of-order/flush counts  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module shufflev_issue_scheduler
  import shufflev_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEFAULT,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_ni,
  input  wire logic                     flush_i,
  shufflev_issue_scheduler_if.slave     sched_if,
  input  wire logic                     shuffle_en_i,
  input  wire logic                     seed_load_i,
  input  wire logic [LFSR_W-1:0]        seed_i,
  output logic      [$clog2(DEPTH):0]   occupancy_o
`ifdef SHUFFLEV_SCHED_PERF_EN
  ,
  output logic      [31:0]              perf_ooo_cnt_o,
  output logic      [31:0]              perf_flush_cnt_o
`endif
);

  localparam int               IDX_W       = $clog2(DEPTH);
  localparam logic [IDX_W:0]   c_DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   c_ONE_CNT   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(DEPTH - 1);

  slot_state_t [DEPTH-1:0] r_slots;
  logic                    r_barrier_pending;
  logic                    r_shuffle_mode;
  logic [IDX_W-1:0]        r_alloc_ptr;
  logic [IDX_W-1:0]        r_head_ptr;

  logic [7:0]              w_rand;
  logic [DEPTH-1:0]        w_valid;
  logic [DEPTH-1:0]        w_barrier;
  logic [DEPTH-1:0]        w_nonbar;
  logic [DEPTH-1:0]        w_cand;
  logic [IDX_W:0]          w_occ;
  logic [IDX_W-1:0]        w_start;
  logic [IDX_W-1:0]        w_push_idx;
  logic [IDX_W-1:0]        w_pop_idx;
  logic                    w_push_ready;
  logic                    w_pop_valid;
  logic                    w_push_hs;
  logic                    w_pop_hs;

  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx);
    return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_bits
    assign w_valid[gi]   = r_slots[gi].valid;
    assign w_barrier[gi] = r_slots[gi].barrier;
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + (IDX_W+1)'(w_valid[i]);
    end
  end

  // A barrier only becomes issuable once everything older has drained.
  assign w_nonbar = w_valid & ~w_barrier;
  assign w_cand   = (|w_nonbar) ? w_nonbar : ((w_occ == c_ONE_CNT) ? w_valid : '0);
  assign w_start  = r_shuffle_mode ? IDX_W'(w_rand % 8'(DEPTH)) : r_head_ptr;

  always_comb begin
    w_push_idx = IDX_W'(first_set_circ(MAX_DEPTH'(~w_valid), int'(r_alloc_ptr), DEPTH));
    w_pop_idx  = IDX_W'(first_set_circ(MAX_DEPTH'(w_cand), int'(w_start), DEPTH));
  end

  assign w_push_ready = !flush_i && !r_barrier_pending && (w_occ < c_DEPTH_CNT);
  assign w_pop_valid  = (|w_cand) && !flush_i;
  assign w_push_hs    = sched_if.push_i && w_push_ready;
  assign w_pop_hs     = w_pop_valid && sched_if.pop_ready_i;

  assign sched_if.push_ready_o = w_push_ready;
  assign sched_if.push_idx_o   = w_push_idx;
  assign sched_if.pop_valid_o  = w_pop_valid;
  assign sched_if.pop_idx_o    = w_pop_idx;
  assign occupancy_o           = w_occ;

  shufflev_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (seed_load_i),
    .seed_i    (seed_i),
    .advance_i (w_pop_hs),
    .rand_o    (w_rand)
  );

  // Push allocates from pre-pop state, so the popped slot is never reused in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slots           <= '0;
      r_barrier_pending <= 1'b0;
      r_alloc_ptr       <= '0;
      r_head_ptr        <= '0;
      r_shuffle_mode    <= 1'b0;
    end else begin
      if (w_occ == '0) r_shuffle_mode <= shuffle_en_i;
      if (flush_i) begin
        r_slots           <= '0;
        r_barrier_pending <= 1'b0;
        r_head_ptr        <= r_alloc_ptr;
      end else begin
        if (w_pop_hs) begin
          r_slots[w_pop_idx] <= '0;
          r_head_ptr         <= f_next_idx(w_pop_idx);
          if (r_slots[w_pop_idx].barrier) r_barrier_pending <= 1'b0;
        end
        if (w_push_hs) begin
          r_slots[w_push_idx] <= slot_state_t'{valid: 1'b1, barrier: sched_if.push_barrier_i};
          r_alloc_ptr         <= f_next_idx(w_push_idx);
          if (sched_if.push_barrier_i) r_barrier_pending <= 1'b1;
        end
      end
    end
  end

`ifdef SHUFFLEV_SCHED_PERF_EN
  logic [31:0] r_perf_ooo;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_ooo   <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_pop_hs && (w_pop_idx != r_head_ptr) && (r_perf_ooo != '1)) begin
        r_perf_ooo <= r_perf_ooo + 32'd1;
      end
      if (flush_i && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_ooo_cnt_o   = r_perf_ooo;
  assign perf_flush_cnt_o = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shufflev_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shufflev_issue_scheduler: directed stimulus with pop-order scoreboard   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_shufflev_issue_scheduler;
  import shufflev_pkg::*;

  localparam int DEPTH = 5;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             shuffle_en_i;
  logic             seed_load_i;
  logic [15:0]      seed_i;
  logic [IDX_W:0]   occupancy_o;
`ifdef SHUFFLEV_SCHED_PERF_EN
  logic [31:0]      perf_ooo_cnt_o;
  logic [31:0]      perf_flush_cnt_o;
`endif

  shufflev_issue_scheduler_if #(.DEPTH(DEPTH)) sif ();

  shufflev_issue_scheduler #(
    .DEPTH     (DEPTH),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .sched_if         (sif),
    .shuffle_en_i     (shuffle_en_i),
    .seed_load_i      (seed_load_i),
    .seed_i           (seed_i),
    .occupancy_o      (occupancy_o)
`ifdef SHUFFLEV_SCHED_PERF_EN
    ,
    .perf_ooo_cnt_o   (perf_ooo_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;
  int exp_pop_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared against the next queued slot.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && sif.pop_valid_o === 1'b1 && sif.pop_ready_i === 1'b1) begin
      if (exp_pop_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got idx %0d, required no pop", sif.pop_idx_o);
      end else begin
        check("pop_idx", 32'(sif.pop_idx_o), 32'(exp_pop_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic bar, input int exp_idx);
    sif.push_i         = 1'b1;
    sif.push_barrier_i = bar;
    @(negedge clk_i);
    check("push_ready", 32'(sif.push_ready_o), 32'd1);
    check("push_idx", 32'(sif.push_idx_o), 32'(exp_idx));
    step();
    sif.push_i         = 1'b0;
    sif.push_barrier_i = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load_i = 1'b1;
    seed_i      = s;
    step();
    seed_load_i = 1'b0;
  endtask

  task automatic expect_pops(input int a, input int b, input int c, input int d, input int e, input int n);
    int v[5];
    v = '{a, b, c, d, e};
    for (int i = 0; i < n; i++) exp_pop_q.push_back(v[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    sif.pop_ready_i = 1'b1;
    while (occupancy_o != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_empty", 32'(occupancy_o), 32'd0);
    sif.pop_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst_ni             = 1'b0;
    flush_i            = 1'b0;
    shuffle_en_i       = 1'b0;
    seed_load_i        = 1'b0;
    seed_i             = 16'h0;
    sif.push_i         = 1'b0;
    sif.push_barrier_i = 1'b0;
    sif.pop_ready_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_push_ready", 32'(sif.push_ready_o), 32'd1);
    check("rst_push_idx", 32'(sif.push_idx_o), 32'd0);
    check("rst_pop_valid", 32'(sif.pop_valid_o), 32'd0);
    check("rst_pop_idx", 32'(sif.pop_idx_o), 32'd0);
    check("rst_occupancy", 32'(occupancy_o), 32'd0);
    step();

    // FIFO order, full boundary with a simultaneous pop attempt
    for (int i = 0; i < 5; i++) push(1'b0, i);
    expect_pops(0, 1, 2, 3, 4, 5);
    @(negedge clk_i);
    check("full_push_ready", 32'(sif.push_ready_o), 32'd0);
    check("full_occupancy", 32'(occupancy_o), 32'd5);
    step();
    sif.push_i      = 1'b1;
    sif.pop_ready_i = 1'b1;
    @(negedge clk_i);
    check("full_pop_push_ready", 32'(sif.push_ready_o), 32'd0);
    check("full_pop_valid", 32'(sif.pop_valid_o), 32'd1);
    step();
    sif.push_i = 1'b0;
    check("after_pop_occupancy", 32'(occupancy_o), 32'd4);
    drain();
`ifdef SHUFFLEV_SCHED_PERF_EN
    check("perf_ooo_fifo", perf_ooo_cnt_o, 32'd0);
`endif

    // Barrier fencing in shuffle mode, seed 1
    shuffle_en_i = 1'b1;
    load_seed(16'h0001);
    push(1'b0, 0);
    push(1'b0, 1);
    push(1'b0, 2);
    push(1'b1, 3);
    @(negedge clk_i);
    check("barrier_push_ready", 32'(sif.push_ready_o), 32'd0);
    check("barrier_occupancy", 32'(occupancy_o), 32'd4);
    step();
    expect_pops(1, 0, 2, 3, 0, 4);
    drain();
    @(negedge clk_i);
    check("barrier_released", 32'(sif.push_ready_o), 32'd1);
    step();

    // Randomised order from reloaded seed, full buffer
    load_seed(16'h0001);
    push(1'b0, 4);
    push(1'b0, 0);
    push(1'b0, 1);
    push(1'b0, 2);
    push(1'b0, 3);
    check("rand_occupancy", 32'(occupancy_o), 32'd5);
    expect_pops(1, 0, 2, 3, 4, 5);
    drain();

    // Flush with push and pop offered; LFSR must hold (expected state 0x0B40)
    push(1'b0, 4);
    push(1'b0, 0);
    push(1'b0, 1);
    push(1'b0, 2);
    flush_i         = 1'b1;
    sif.push_i      = 1'b1;
    sif.pop_ready_i = 1'b1;
    @(negedge clk_i);
    check("flush_pop_valid", 32'(sif.pop_valid_o), 32'd0);
    check("flush_push_ready", 32'(sif.push_ready_o), 32'd0);
    step();
    flush_i         = 1'b0;
    sif.push_i      = 1'b0;
    sif.pop_ready_i = 1'b0;
    @(negedge clk_i);
    check("post_flush_occupancy", 32'(occupancy_o), 32'd0);
    check("post_flush_push_idx", 32'(sif.push_idx_o), 32'd3);
    step();
    push(1'b0, 3);
    push(1'b0, 4);
    expect_pops(4, 3, 0, 0, 0, 2);
    drain();

    // Zero seed substitution and mode held while occupied
    load_seed(16'h0000);
    push(1'b0, 0);
    push(1'b0, 1);
    check("mode_occupancy", 32'(occupancy_o), 32'd2);
    shuffle_en_i = 1'b0;
    push(1'b0, 2);
    push(1'b0, 3);
    push(1'b0, 4);
    expect_pops(1, 0, 2, 3, 4, 5);
    drain();

`ifdef SHUFFLEV_SCHED_PERF_EN
    flush_i = 1'b1;
    step();
    step();
    flush_i = 1'b0;
    check("perf_flush_cnt", perf_flush_cnt_o, 32'd3);
`endif

    step();
    check("scoreboard_empty", 32'(exp_pop_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shufflev_issue_scheduler.md
Name: shufflev_issue_scheduler

Overview:
Slot scheduler for the shuffling instruction buffer. It allocates buffer slots for incoming fetched instructions and picks which valid slot issues next, using an LFSR-driven randomised order. Control-flow instructions act as barriers: no instruction is shuffled across one. The block sits between the core-side fetch handshake and the slot storage. It owns only control state; it holds no instruction data.

Parameters:
DEPTH, 5, number of buffer slots (2..16).
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
IDX_W, $clog2(DEPTH), slot index width (derived, not overridable).

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
flush_i  in  1  branch/redirect; discards all slots
push_i  in  1  new instruction offered for storage
push_barrier_i  in  1  offered instruction is jump/branch/fence/ecall
push_ready_o  out  1  a slot can be allocated this cycle
push_idx_o  out  IDX_W  slot to be written when push_i && push_ready_o
pop_valid_o  out  1  an issuable slot exists
pop_idx_o  out  IDX_W  slot to issue
pop_ready_i  in  1  core consumes pop_idx_o this cycle
shuffle_en_i  in  1  requested randomisation mode
seed_load_i  in  1  load seed_i into LFSR
seed_i  in  16  new LFSR seed
occupancy_o  out  IDX_W+1  number of valid slots

Behaviour:
- Reset: valid_q=0, barrier_q=0, barrier_pending_q=0, alloc_ptr_q=0, head_ptr_q=0, lfsr_q=LFSR_SEED, shuffle_mode_q=0. Outputs after reset: push_ready_o=1, push_idx_o=0, pop_valid_o=0, pop_idx_o=0, occupancy_o=0.
- State: per slot valid_q and barrier_q; barrier_pending_q is set while a barrier slot is held.
- Allocation: push_idx_o is the first free slot scanning circularly from alloc_ptr_q. On a push handshake that slot is marked valid, barrier_q[slot]=push_barrier_i, and alloc_ptr_q moves to slot+1 mod DEPTH.
- push_ready_o = !flush_i && !barrier_pending_q && (occupancy < DEPTH). Because pushes are blocked once a barrier is stored, a barrier is always the youngest entry.
- A push handshake with push_barrier_i=1 sets barrier_pending_q.
- Issue candidates: all valid non-barrier slots. A barrier slot is a candidate only when it is the sole valid slot.
- Start point:
  - shuffle_mode_q=1: start = lfsr_q[7:0] % DEPTH (constant modulus).
  - shuffle_mode_q=0: start = head_ptr_q.
- pop_idx_o is the first candidate at or after start, wrapping. pop_valid_o = any candidate && !flush_i. The output is combinational from registered state (zero latency).
- Pop handshake (pop_valid_o && pop_ready_i):
  - clear the slot's valid and barrier bits;
  - head_ptr_q moves to pop_idx_o+1 mod DEPTH;
  - if the slot held a barrier, clear barrier_pending_q (branch not taken; fetch resumes);
  - lfsr_q advances one step.
- LFSR: 16-bit Galois, taps 16'hB400, shifting right. It advances only on pop handshakes. seed_load_i takes priority over advancing; a seed of 0 loads 16'h0001.
- Mode: shuffle_mode_q <= shuffle_en_i only in cycles where occupancy is 0. Otherwise the mode holds, so FIFO order stays valid.
- Simultaneous push and pop are both performed in one cycle. Allocation uses pre-pop state, so the popped slot is not reused that cycle. When full, push_ready_o=0 even if a pop occurs that cycle.
- flush_i has top priority:
  - next state: valid_q=0, barrier_q=0, barrier_pending_q=0, head_ptr_q=alloc_ptr_q;
  - any push or pop in the same cycle is ignored; the LFSR does not advance.
- Reset asserted mid-operation returns all state to reset values asynchronously.
- occupancy_o = popcount(valid_q).

Optional Feature:
SHUFFLEV_SCHED_PERF_EN:
- Defined: adds outputs perf_ooo_cnt_o[31:0] and perf_flush_cnt_o[31:0], both reset to 0 and saturating.
  - perf_ooo_cnt_o increments on each pop handshake where pop_idx_o != head_ptr_q.
  - perf_flush_cnt_o increments on each flush_i cycle.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package shufflev_pkg: LFSR_W=16, LFSR_TAPS=16'hB400, LFSR_SEED_DEFAULT, DEPTH_DEFAULT=5, and a slot-state struct typedef (valid, barrier).
- Sub-module shufflev_lfsr: 16-bit Galois LFSR with load, advance and zero-seed guard.
- Circular first-set search as a package function shared by allocation and issue selection.

Test Plan:
- FIFO mode, no barriers: shuffle_en_i=0, push 5 instructions, then pop with pop_ready_i=1 -> pop_idx_o sequence 0,1,2,3,4; push_ready_o=0 after the 5th push; occupancy_o 5 then 0.
- Barrier fencing: shuffle on, push 3 non-barriers then 1 barrier (slot 3) -> push_ready_o=0. The barrier slot is not issued until the other three are popped; after it pops, push_ready_o=1.
- Random order matches model: seed_load_i with seed_i=16'h0001, fill 5, pop all -> pop_idx_o matches a scoreboard LFSR model; every slot issues exactly once.
- Flush mid-stream: 4 valid slots, flush_i with push_i=1 and pop_ready_i=1 -> pop_valid_o=0 that cycle; next cycle occupancy_o=0; LFSR unchanged; next push_idx_o = previous alloc_ptr_q.
- Zero seed and mode latch: seed_i=0 -> lfsr_q=16'h0001. Toggling shuffle_en_i while occupancy=2 has no effect until the buffer empties.
- Perf (SHUFFLEV_SCHED_PERF_EN defined): FIFO run -> perf_ooo_cnt_o=0; 3 flushes -> perf_flush_cnt_o=3.
